spatz_cache_demux: RTL and testbench



---
 rtl/spatz_cache_demux.sv | 172 +++++++++++++++++
 tb/tb_spatz_cache_demux.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spatz_cache_demux.sv
// -----------------------------------------------------------------------------
// spatz_cache_demux
//
// Response-side companion of the two-port cache request arbiter. Every request
// accepted downstream has its winning port ID pushed into a small circular
// tracker FIFO. The in-order cache controller responses are then steered back
// to the port at the head of that FIFO. The tracker bounds the number of
// outstanding requests through req_gate_o, which upstream ANDs into the
// downstream ready.
//
// Optional feature, selected by the macro SPATZ_CACHE_DEMUX_CUT_EN:
//   defined   : each port gets a one-entry output register (valid + data), so
//               there is a 1-cycle response latency and per-port full throughput.
//   undefined : purely combinational routing with no response-path storage.
//
// Valid/ready semantics (applies to every handshake on this block):
//   A transfer happens in a cycle where valid and ready are both high at the
//   rising edge. Once valid is raised it stays high, with its data stable,
//   until the transfer completes. Valid never waits for ready. Ready may depend
//   on valid only on the error-drop path (a response arriving while the tracker
//   is empty).
//
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   req_valid_i   : request valid at the arbiter output
//   req_ready_i   : downstream ready as seen by the arbiter output
//   req_port_i    : port that won the current request
//   req_gate_o    : tracker has room for one more outstanding request
//   rsp_data_i    : response payload from the cache controller
//   rsp_valid_i   : response valid
//   rsp_ready_o   : response accepted
//   oup_data_o    : per-port response payload
//   oup_valid_o   : per-port response valid
//   oup_ready_i   : per-port response ready
//   err_o         : sticky, set when a response arrives with the tracker empty
// -----------------------------------------------------------------------------
module spatz_cache_demux #(
  parameter type         DATA_T = logic,
  parameter int unsigned Depth  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_ready_i,
  input  logic        req_port_i,
  output logic        req_gate_o,
  input  DATA_T       rsp_data_i,
  input  logic        rsp_valid_i,
  output logic        rsp_ready_o,
  output DATA_T [1:0] oup_data_o,
  output logic  [1:0] oup_valid_o,
  input  logic  [1:0] oup_ready_i,
  output logic        err_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  // Tracker storage and bookkeeping
  logic [Depth-1:0] ids;
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;

  logic empty;
  logic head;
  logic push;
  logic pop;

  assign empty = (count == '0);
  assign head  = ids[rd_ptr];

  // The gate looks at the registered count only, so a pop in the same cycle
  // never frees a slot for a same-cycle push. This keeps req_gate_o free of any
  // combinational path from the response side.
  assign req_gate_o = (count != CntW'(Depth));
  assign push       = req_valid_i && req_ready_i && req_gate_o;

  // A response accepted while the tracker is empty is a drop, not a pop, so
  // the read pointer and the count are left untouched.
  assign pop = rsp_valid_i && rsp_ready_o && !empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ids    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ids[wr_ptr] <= req_port_i;
        // Depth is a power of two, so the natural pointer overflow wraps it.
        wr_ptr      <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flag: a response showed up with nothing outstanding.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (rsp_valid_i && empty) begin
      err_o <= 1'b1;
    end
  end

`ifdef SPATZ_CACHE_DEMUX_CUT_EN

  // One-entry output register per port.
  logic  [1:0] reg_valid;
  DATA_T [1:0] reg_data;

  always_comb begin
    rsp_ready_o = 1'b0;
    if (empty) begin
      // Error-drop path: swallow the stray response.
      rsp_ready_o = rsp_valid_i;
    end else begin
      // The head port's register can take a new entry if it is free or is
      // being drained in this very cycle.
      rsp_ready_o = !reg_valid[head] || oup_ready_i[head];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_valid <= '0;
      reg_data  <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (pop && (head == p[0])) begin
          reg_valid[p] <= 1'b1;
          reg_data[p]  <= rsp_data_i;
        end else if (oup_ready_i[p]) begin
          reg_valid[p] <= 1'b0;
        end
      end
    end
  end

  assign oup_valid_o = reg_valid;
  assign oup_data_o  = reg_data;

`else

  always_comb begin
    oup_valid_o = 2'b00;
    rsp_ready_o = 1'b0;
    if (empty) begin
      // Error-drop path: swallow the stray response, raise no output valid.
      rsp_ready_o = rsp_valid_i;
    end else begin
      oup_valid_o[head] = rsp_valid_i;
      rsp_ready_o       = oup_ready_i[head];
    end
  end

  // Payload fans out to both ports; only the valid selects the receiver.
  assign oup_data_o[0] = rsp_data_i;
  assign oup_data_o[1] = rsp_data_i;

`endif

endmodule

// File: tb/tb_spatz_cache_demux.sv
// -----------------------------------------------------------------------------
// tb_spatz_cache_demux
//
// Self-checking bench for spatz_cache_demux in its default (combinational
// routing) build. The reference model is a queue of outstanding port IDs:
// pushes append, accepted responses take the front, and the head decides which
// port sees the response. Directed scenarios are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_spatz_cache_demux;

  localparam int DEPTH = 4;
  typedef logic [7:0] data_t;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic        req_valid = 1'b0;
  logic        req_ready = 1'b0;
  logic        req_port  = 1'b0;
  logic        req_gate;
  data_t       rsp_data  = '0;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  data_t [1:0] oup_data;
  logic  [1:0] oup_valid;
  logic  [1:0] oup_ready = 2'b00;
  logic        err;

  spatz_cache_demux #(
    .DATA_T (data_t),
    .Depth  (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_i (req_ready),
    .req_port_i  (req_port),
    .req_gate_o  (req_gate),
    .rsp_data_i  (rsp_data),
    .rsp_valid_i (rsp_valid),
    .rsp_ready_o (rsp_ready),
    .oup_data_o  (oup_data),
    .oup_valid_o (oup_valid),
    .oup_ready_i (oup_ready),
    .err_o       (err)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard: outstanding port IDs in request order, plus sticky error
  // ---------------------------------------------------------------------------
  logic [0:0] exp_q[$];
  logic       exp_err = 1'b0;
  int         n_cmp   = 0;
  int         n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic rv, input logic rr, input logic port,
                       input logic rspv, input data_t d, input logic [1:0] ordy);
    req_valid = rv;
    req_ready = rr;
    req_port  = port;
    rsp_valid = rspv;
    rsp_data  = d;
    oup_ready = ordy;
  endtask

  // One clock cycle with the currently driven inputs: predict outputs from the
  // model, compare at the falling edge, then advance the model past the rising
  // edge.
  task automatic tick();
    logic       exp_gate;
    logic       exp_rrdy;
    logic [1:0] exp_valid;
    logic       do_push;
    logic       do_pop;
    logic       was_empty;
    logic [0:0] hd;
    was_empty = (exp_q.size() == 0);
    exp_gate  = (exp_q.size() != DEPTH);
    do_push   = req_valid && req_ready && exp_gate;
    exp_valid = 2'b00;
    do_pop    = 1'b0;
    if (!was_empty) begin
      hd        = exp_q[0];
      exp_rrdy  = oup_ready[hd];
      if (rsp_valid) exp_valid[hd] = 1'b1;
      do_pop    = rsp_valid && exp_rrdy;
    end else begin
      exp_rrdy  = rsp_valid;
    end
    @(negedge clk);
    check("req_gate",  {31'b0, req_gate},  {31'b0, exp_gate});
    check("rsp_ready", {31'b0, rsp_ready}, {31'b0, exp_rrdy});
    check("oup_valid", {30'b0, oup_valid}, {30'b0, exp_valid});
    check("err",       {31'b0, err},       {31'b0, exp_err});
    if (rsp_valid) check("oup_data", {16'b0, oup_data}, {16'b0, rsp_data, rsp_data});
    @(posedge clk);
    #1;
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(req_port);
    if (rsp_valid && was_empty) exp_err = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b11);
      tick();
    end
  endtask

  task automatic push_one(input logic port);
    drive(1'b1, 1'b1, port, 1'b0, '0, 2'b11);
    tick();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 2'b00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [0:0] order[4];
    data_t      rsp_vals[4];
    order    = '{1'b0, 1'b1, 1'b1, 1'b0};
    rsp_vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    // Reset, then idle for 10 cycles
    @(posedge clk);
    #1;
    do_reset();
    idle(10);

    // Push 0,1,1,0 then responses A..D with all readies high
    for (int i = 0; i < 4; i++) push_one(order[i]);
    check("depth_after_4_pushes", exp_q.size(), DEPTH);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, rsp_vals[i], 2'b11);
      tick();
    end
    idle(2);

    // Full tracker: push attempt with a same-cycle pop must not push
    for (int i = 0; i < 4; i++) push_one(i[0]);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 2'b11);
    tick();
    check("count_after_full_pop", exp_q.size(), DEPTH - 1);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, data_t'(8'h60 + i), 2'b11);
      tick();
    end

    // Head = port1 with only port0 ready: stalled, then released
    push_one(1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 2'b01);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 2'b11);
    tick();
    idle(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic rspv;
      if (exp_q.size() != 0) rspv = 1'($urandom_range(0, 1));
      else                   rspv = ($urandom_range(0, 31) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            rspv, data_t'($urandom_range(0, 255)), 2'($urandom_range(0, 3)));
      tick();
    end
    do_reset();
    idle(2);

    // Reset with 3 outstanding entries: tracker must be empty afterwards
    for (int i = 0; i < 3; i++) push_one(1'b1);
    do_reset();
    idle(1);
    for (int i = 0; i < 5; i++) push_one(1'b0);
    check("count_after_reset_refill", exp_q.size(), DEPTH);
    do_reset();
    idle(1);

    // Response with empty tracker: dropped, sticky error until reset
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE, 2'b00);
    tick();
    idle(5);
    push_one(1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'b10);
    tick();
    idle(2);
    do_reset();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Absolute time bound in case something stalls the stimulus process
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
